// File: rtl/cpu_trace_buffer_if.sv
//------------------------------------------------------------------------------
// Module      : cpu_trace_buffer_if
// Description : Valid/ready drain port of the CPU trace buffer. The buffer
//               drives the record head (master); the host consumes it (slave).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cpu_trace_buffer_if;
    logic        out_valid;
    logic        out_ready;
    logic [77:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/cpu_trace_buffer.sv
//------------------------------------------------------------------------------
// Module      : cpu_trace_buffer
// Description : Groups CPU writeIR/writeReg/done/err strobes into one trace
//               record per executed instruction and queues the records in a
//               circular FIFO drained through a valid/ready port. Records that
//               arrive while the FIFO is full are dropped and counted.
//               Record format: {reg_written, err_flag, PC, IR, F, nzcv}.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               CP,
    input  logic               reset,
    input  logic               writeIR,
    input  logic               writeReg,
    input  logic [7:0]         PC,
    input  logic [31:0]        IR,
    input  logic [31:0]        F,
    input  logic [3:0]         nzcv,
    input  logic               done,
    input  logic               err,
    cpu_trace_buffer_if.master trc,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic               halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q;
    logic [7:0]         pc_q;
    logic [31:0]        ir_q;
    logic [31:0]        f_q;
    logic               rw_q;
    logic               halted_q;

    logic [77:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    logic               w_push;
    logic               w_err;
    logic [77:0]        w_rec;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_accept;
    logic               w_drop;

    // Close decision for the open record; a same-cycle writeReg belongs to it
    always_comb begin
        w_push = 1'b0;
        w_err  = 1'b0;
        if (state_q == S_OPEN && (writeIR || done || err)) begin
            w_push = 1'b1;
            w_err  = err;
        end
        w_rec = {rw_q | writeReg, w_err, pc_q, ir_q, (writeReg ? F : f_q), nzcv};
    end

    // Capture FSM: builds the open record and stops for good after done/err
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            f_q      <= '0;
            rw_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (writeIR) begin
                        pc_q    <= PC;
                        ir_q    <= IR;
                        f_q     <= '0;
                        rw_q    <= 1'b0;
                        state_q <= S_OPEN;
                    end else if (done || err) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end
                S_OPEN: begin
                    if (done || err) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else if (writeIR) begin
                        pc_q <= PC;
                        ir_q <= IR;
                        f_q  <= '0;
                        rw_q <= 1'b0;
                    end else if (writeReg) begin
                        f_q  <= F;
                        rw_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == CNT_W'(DEPTH));
    assign w_pop    = !w_empty && trc.out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    // FIFO pointer, occupancy and drop bookkeeping next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | w_drop;
        drop_cnt_d = drop_cnt_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_accept && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_accept && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        if (w_drop && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // FIFO state registers and record storage
    always_ff @(posedge CP or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            if (w_accept) begin
                mem_q[wr_ptr_q] <= w_rec;
            end
        end
    end

    assign trc.out_valid = !w_empty;
    assign trc.out_data  = w_empty ? '0 : mem_q[rd_ptr_q];
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;
    assign halted        = halted_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_cpu_trace_buffer
// Description : Directed self-checking bench for cpu_trace_buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_trace_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic        CP = 1'b0;
    logic        reset = 1'b0;
    logic        writeIR = 1'b0;
    logic        writeReg = 1'b0;
    logic [7:0]  PC = '0;
    logic [31:0] IR = '0;
    logic [31:0] F = '0;
    logic [3:0]  nzcv = '0;
    logic        done = 1'b0;
    logic        err = 1'b0;
    logic [CNT_W-1:0] count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        halted;

    int checks = 0;
    int errors = 0;

    cpu_trace_buffer_if trc_if ();

    cpu_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CP       (CP),
        .reset    (reset),
        .writeIR  (writeIR),
        .writeReg (writeReg),
        .PC       (PC),
        .IR       (IR),
        .F        (F),
        .nzcv     (nzcv),
        .done     (done),
        .err      (err),
        .trc      (trc_if),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .halted   (halted)
    );

    always #5 CP = ~CP;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic logic [77:0] mk_rec(input logic rw, input logic e, input logic [7:0] pc,
                                           input logic [31:0] ir, input logic [31:0] f,
                                           input logic [3:0] nz);
        return {rw, e, pc, ir, f, nz};
    endfunction

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic clr_in();
        writeIR  = 1'b0;
        writeReg = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        trc_if.out_ready = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        trc_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            writeIR  = 1'($urandom_range(0, 1));
            writeReg = 1'($urandom_range(0, 1));
            done     = 1'($urandom_range(0, 1));
            err      = 1'($urandom_range(0, 1));
            PC       = 8'($urandom);
            IR       = $urandom;
            F        = $urandom;
            tick();
            checks++;
            if (count !== '0) begin
                errors++;
                $display("FAIL reset_count: got %0d expected 0", count);
            end
        end
        checks++;
        if (trc_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", trc_if.out_valid);
        end
        checks++;
        if (trc_if.out_data !== 78'd0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", trc_if.out_data);
        end
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ovf=%b drop=%0d halt=%b expected 0 0 0",
                     overflow, drop_cnt, halted);
        end
        clr_in();
        trc_if.out_ready = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_single_instr();
        do_reset();
        writeIR = 1'b1; PC = 8'h04; IR = 32'hE3A01005;
        tick();
        writeIR = 1'b0; writeReg = 1'b1; F = 32'd5;
        tick();
        writeReg = 1'b0; done = 1'b1; nzcv = 4'b0000;
        tick();
        done = 1'b0;
        checks++;
        if (count !== 4'd1 || trc_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_count: got count=%0d valid=%b expected 1 1", count, trc_if.out_valid);
        end
        checks++;
        if (trc_if.out_data !== mk_rec(1'b1, 1'b0, 8'h04, 32'hE3A01005, 32'd5, 4'h0)) begin
            errors++;
            $display("FAIL single_data: got %h expected %h", trc_if.out_data,
                     mk_rec(1'b1, 1'b0, 8'h04, 32'hE3A01005, 32'd5, 4'h0));
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL single_halted: got %b expected 1", halted);
        end
        trc_if.out_ready = 1'b1;
        tick();
        trc_if.out_ready = 1'b0;
        checks++;
        if (count !== 4'd0 || trc_if.out_data !== 78'd0) begin
            errors++;
            $display("FAIL single_pop: got count=%0d data=%h expected 0 0", count, trc_if.out_data);
        end
    endtask

    task automatic test_no_reg_write();
        do_reset();
        writeIR = 1'b1; PC = 8'h00; IR = 32'hAAAA0000;
        tick();
        PC = 8'h04; IR = 32'hBBBB0004; nzcv = 4'b1010;
        tick();
        checks++;
        if (count !== 4'd1 || trc_if.out_data !== mk_rec(1'b0, 1'b0, 8'h00, 32'hAAAA0000, 32'd0, 4'b1010)) begin
            errors++;
            $display("FAIL noreg_rec: got count=%0d data=%h expected 1 %h", count, trc_if.out_data,
                     mk_rec(1'b0, 1'b0, 8'h00, 32'hAAAA0000, 32'd0, 4'b1010));
        end
        writeReg = 1'b1; F = 32'd77; PC = 8'h08; IR = 32'hCCCC0008; nzcv = 4'b0011;
        tick();
        clr_in();
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL noreg_count2: got %0d expected 2", count);
        end
        trc_if.out_ready = 1'b1;
        tick();
        trc_if.out_ready = 1'b0;
        checks++;
        if (trc_if.out_data !== mk_rec(1'b1, 1'b0, 8'h04, 32'hBBBB0004, 32'd77, 4'b0011)) begin
            errors++;
            $display("FAIL samecycle_rec: got %h expected %h", trc_if.out_data,
                     mk_rec(1'b1, 1'b0, 8'h04, 32'hBBBB0004, 32'd77, 4'b0011));
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_pc;
        do_reset();
        writeIR = 1'b1; PC = 8'd0; IR = 32'h100;
        tick();
        for (int k = 1; k <= DEPTH + 3; k++) begin
            PC = 8'(k); IR = 32'h100 + 32'(k); nzcv = 4'(k);
            tick();
        end
        writeIR = 1'b0;
        checks++;
        if (count !== 4'(DEPTH) || overflow !== 1'b1 || drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL ovf_state: got count=%0d ovf=%b drop=%0d expected %0d 1 3",
                     count, overflow, drop_cnt, DEPTH);
        end
        checks++;
        if (trc_if.out_data !== mk_rec(1'b0, 1'b0, 8'd0, 32'h100, 32'd0, 4'd1)) begin
            errors++;
            $display("FAIL ovf_head: got %h expected %h", trc_if.out_data,
                     mk_rec(1'b0, 1'b0, 8'd0, 32'h100, 32'd0, 4'd1));
        end
        writeIR = 1'b1; PC = 8'd12; IR = 32'h10C; nzcv = 4'hC; trc_if.out_ready = 1'b1;
        tick();
        writeIR = 1'b0; trc_if.out_ready = 1'b0;
        checks++;
        if (count !== 4'(DEPTH) || drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL full_pushpop_count: got count=%0d drop=%0d expected %0d 3", count, drop_cnt, DEPTH);
        end
        checks++;
        if (trc_if.out_data !== mk_rec(1'b0, 1'b0, 8'd1, 32'h101, 32'd0, 4'd2)) begin
            errors++;
            $display("FAIL full_pushpop_head: got %h expected %h", trc_if.out_data,
                     mk_rec(1'b0, 1'b0, 8'd1, 32'h101, 32'd0, 4'd2));
        end
        trc_if.out_ready = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            exp_pc = (j < DEPTH - 1) ? 8'(j + 1) : 8'd11;
            checks++;
            if (trc_if.out_data[75:68] !== exp_pc) begin
                errors++;
                $display("FAIL ovf_drain_pc: got %h expected %h", trc_if.out_data[75:68], exp_pc);
            end
            tick();
        end
        trc_if.out_ready = 1'b0;
        checks++;
        if (count !== 4'd0 || trc_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drained: got count=%0d valid=%b expected 0 0", count, trc_if.out_valid);
        end
        writeIR = 1'b1;
        for (int k = 0; k < DEPTH + 260; k++) begin
            PC = 8'(k);
            tick();
        end
        writeIR = 1'b0;
        checks++;
        if (drop_cnt !== 8'd255 || count !== 4'(DEPTH)) begin
            errors++;
            $display("FAIL drop_saturate: got drop=%0d count=%0d expected 255 %0d", drop_cnt, count, DEPTH);
        end
    endtask

    task automatic test_err();
        do_reset();
        writeIR = 1'b1; PC = 8'h10; IR = 32'hDEADBEEF;
        tick();
        writeIR = 1'b0; err = 1'b1; done = 1'b1; nzcv = 4'h5;
        tick();
        clr_in();
        checks++;
        if (trc_if.out_data !== mk_rec(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'd0, 4'h5) || count !== 4'd1) begin
            errors++;
            $display("FAIL err_rec: got count=%0d data=%h expected 1 %h", count, trc_if.out_data,
                     mk_rec(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'd0, 4'h5));
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL err_halted: got %b expected 1", halted);
        end
        for (int i = 0; i < 4; i++) begin
            writeIR = 1'b1; writeReg = 1'b1; PC = 8'(i); F = 32'(i);
            tick();
        end
        clr_in();
        tick();
        checks++;
        if (count !== 4'd1 || trc_if.out_data[75:68] !== 8'h10) begin
            errors++;
            $display("FAIL err_nopush: got count=%0d pc=%h expected 1 10", count, trc_if.out_data[75:68]);
        end
    endtask

    task automatic test_wrap_drain();
        logic [77:0] q[$];
        logic [7:0]  o_pc;
        logic [31:0] o_ir, o_f;
        logic        o_rw;
        logic        wir, wreg, rdy;
        logic [31:0] fv, irv;
        logic [3:0]  nz;
        int          pushes;
        do_reset();
        irv = $urandom;
        writeIR = 1'b1; PC = 8'd0; IR = irv;
        tick();
        o_pc = 8'd0; o_ir = irv; o_f = '0; o_rw = 1'b0;
        pushes = 0;
        for (int c = 0; c < 1000 && pushes < 3 * DEPTH; c++) begin
            wir  = ($urandom_range(0, 2) != 0);
            wreg = 1'($urandom_range(0, 1));
            rdy  = 1'($urandom_range(0, 1));
            fv   = $urandom;
            irv  = $urandom;
            nz   = 4'($urandom);
            if (q.size() == DEPTH) rdy = 1'b1;
            checks++;
            if (count !== 4'(q.size())) begin
                errors++;
                $display("FAIL wrap_count: got %0d expected %0d", count, q.size());
            end
            if (rdy && q.size() > 0) begin
                checks++;
                if (trc_if.out_data !== q[0]) begin
                    errors++;
                    $display("FAIL wrap_data: got %h expected %h", trc_if.out_data, q[0]);
                end
                void'(q.pop_front());
            end
            writeIR = wir; writeReg = wreg; F = fv; nzcv = nz;
            PC = 8'(pushes + 1); IR = irv; trc_if.out_ready = rdy;
            if (wir) begin
                q.push_back(mk_rec(o_rw | wreg, 1'b0, o_pc, o_ir, wreg ? fv : o_f, nz));
                pushes++;
                o_pc = 8'(pushes); o_ir = irv; o_f = '0; o_rw = 1'b0;
            end else if (wreg) begin
                o_f = fv; o_rw = 1'b1;
            end
            tick();
        end
        clr_in();
        trc_if.out_ready = 1'b0;
        checks++;
        if (pushes != 3 * DEPTH || count !== 4'(q.size()) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: got pushes=%0d count=%0d ovf=%b expected %0d %0d 0",
                     pushes, count, overflow, 3 * DEPTH, q.size());
        end
        writeIR = 1'b1;
        tick();
        tick();
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || trc_if.out_valid !== 1'b0 || trc_if.out_data !== 78'd0) begin
            errors++;
            $display("FAIL async_reset: got count=%0d valid=%b data=%h expected 0 0 0",
                     count, trc_if.out_valid, trc_if.out_data);
        end
        clr_in();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        trc_if.out_ready = 1'b0;
        test_reset();
        test_single_instr();
        test_no_reg_write();
        test_overflow();
        test_err();
        test_wrap_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
